// File: rtl/alu_unit_dispatcher.sv
// ALU unit dispatcher: accepts one op per handshake, holds a one-hot unit
// enable for a per-unit latency, then pulses Done. Optional macro:
// ALU_ILLEGAL_OP_FLAG_EN adds Illegal_Op / Illegal_Seen outputs.
// Ports: CLK, RST (sync, active-high), ALU_FUN, In_Valid, In_Ready,
//        Unit_Enable, Op_Code, Busy, Done [, Illegal_Op, Illegal_Seen].
module alu_unit_dispatcher #(
  parameter int FUN_WIDTH = 4,
  parameter int SEL_W     = 2,
  parameter int NUM_UNITS = 4,
  parameter int LAT_W     = 4,
  parameter logic [NUM_UNITS*LAT_W-1:0] UNIT_LAT = 16'h1112
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [FUN_WIDTH-1:0]       ALU_FUN,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  output logic [NUM_UNITS-1:0]       Unit_Enable,
  output logic [FUN_WIDTH-SEL_W-1:0] Op_Code,
  output logic                       Busy,
  output logic                       Done
`ifdef ALU_ILLEGAL_OP_FLAG_EN
  ,
  output logic                       Illegal_Op,
  output logic                       Illegal_Seen
`endif
);

  localparam int OP_W = FUN_WIDTH - SEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_UNITS-1:0] en_q, en_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;

  logic [SEL_W-1:0]     sel;
  logic                 accept;
  logic                 legal;
  logic [LAT_W-1:0]     lat_raw;
  logic [NUM_UNITS-1:0] hot;

  assign sel      = ALU_FUN[FUN_WIDTH-1 -: SEL_W];
  assign In_Ready = (state_q != EXEC);
  assign accept   = In_Valid && In_Ready;

  // Select lookup; an out-of-range select leaves hot/lat at zero,
  // which yields an all-zero enable held for a single cycle.
  always_comb begin
    legal   = 1'b0;
    hot     = '0;
    lat_raw = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (sel == SEL_W'(u)) begin
        legal   = 1'b1;
        hot[u]  = 1'b1;
        lat_raw = UNIT_LAT[u*LAT_W +: LAT_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = EXEC;
          en_d    = hot;
          op_d    = ALU_FUN[OP_W-1:0];
          // Latency 0 behaves as 1: counter starts at 0 either way.
          cnt_d   = (lat_raw == '0) ? '0 : lat_raw - LAT_W'(1);
        end else begin
          state_d = IDLE;
          en_d    = '0;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end else begin
          state_d = DONE;
          en_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      en_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Unit_Enable = en_q;
  assign Op_Code     = op_q;
  assign Busy        = (state_q == EXEC);
  assign Done        = (state_q == DONE);

`ifdef ALU_ILLEGAL_OP_FLAG_EN
  logic ill_q, ill_d;
  logic seen_q, seen_d;

  always_comb begin
    ill_d  = ill_q;
    seen_d = seen_q;
    if (accept) begin
      ill_d  = !legal;
      seen_d = seen_q || !legal;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ill_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      ill_q  <= ill_d;
      seen_q <= seen_d;
    end
  end

  assign Illegal_Op   = (state_q == DONE) && ill_q;
  assign Illegal_Seen = seen_q;
`endif

endmodule

// File: tb/tb_alu_unit_dispatcher.sv
// Self-checking bench for alu_unit_dispatcher: directed and random ops
// on a default instance and a 3-unit instance with a zero latency.
module tb_alu_unit_dispatcher;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] ALU_FUN;
  logic       v4, v3;

  logic       r4, r3, b4, b3, d4, d3;
  logic [3:0] en4;
  logic [2:0] en3;
  logic [1:0] op4, op3;
`ifdef ALU_ILLEGAL_OP_FLAG_EN
  logic       io4, is4, io3, is3;
`endif

  always #5 CLK = ~CLK;

  alu_unit_dispatcher u_dut4 (
    .CLK(CLK), .RST(RST), .ALU_FUN(ALU_FUN), .In_Valid(v4),
    .In_Ready(r4), .Unit_Enable(en4), .Op_Code(op4),
    .Busy(b4), .Done(d4)
`ifdef ALU_ILLEGAL_OP_FLAG_EN
    , .Illegal_Op(io4), .Illegal_Seen(is4)
`endif
  );

  alu_unit_dispatcher #(
    .NUM_UNITS(3), .UNIT_LAT(12'h012)
  ) u_dut3 (
    .CLK(CLK), .RST(RST), .ALU_FUN(ALU_FUN), .In_Valid(v3),
    .In_Ready(r3), .Unit_Enable(en3), .Op_Code(op3),
    .Busy(b3), .Done(d3)
`ifdef ALU_ILLEGAL_OP_FLAG_EN
    , .Illegal_Op(io3), .Illegal_Seen(is3)
`endif
  );

  int checks = 0;
  int failures = 0;
  int which = 0;
  bit seen_exp = 1'b0;

  logic [3:0] o_en;
  logic       o_rdy, o_busy, o_done;
  logic [1:0] o_op;
  logic       o_io, o_is;

  always_comb begin
    o_en = en4; o_rdy = r4; o_busy = b4; o_done = d4; o_op = op4;
    o_io = 1'b0; o_is = 1'b0;
`ifdef ALU_ILLEGAL_OP_FLAG_EN
    o_io = io4; o_is = is4;
`endif
    if (which == 1) begin
      o_en = {1'b0, en3}; o_rdy = r3; o_busy = b3; o_done = d3; o_op = op3;
`ifdef ALU_ILLEGAL_OP_FLAG_EN
      o_io = io3; o_is = is3;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_valid(input logic v);
    if (which == 0) v4 = v;
    else v3 = v;
  endtask

  function automatic int n_units();
    return (which == 1) ? 3 : 4;
  endfunction

  // Enable-hold cycles for a select, from the latency table.
  function automatic int ref_lat(input int s);
    int vec, f;
    vec = (which == 1) ? 32'h012 : 32'h1112;
    if (s >= n_units()) return 1;
    f = (vec >> (4 * s)) & 15;
    return (f == 0) ? 1 : f;
  endfunction

  function automatic logic [3:0] ref_en(input int s);
    if (s >= n_units()) return 4'b0000;
    return 4'(1 << s);
  endfunction

  // Issue one op (dispatcher must be ready) and check it to its Done.
  task automatic run_op(input logic [3:0] fun, input bit stall);
    int s, L;
    logic [3:0] e;
    logic [1:0] op;
    s  = int'(fun[3:2]);
    L  = ref_lat(s);
    e  = ref_en(s);
    op = fun[1:0];
    ALU_FUN = fun;
    set_valid(1'b1);
    chk("ready_pre", 32'(o_rdy), 32'd1);
    tick();
    for (int k = 0; k < L; k++) begin
      chk("exec_en", 32'(o_en), 32'(e));
      chk("exec_busy", 32'(o_busy), 32'd1);
      chk("exec_done", 32'(o_done), 32'd0);
      chk("exec_ready", 32'(o_rdy), 32'd0);
      chk("exec_op", 32'(o_op), 32'(op));
      set_valid(stall);
      ALU_FUN = 4'($urandom);
      tick();
    end
    if (s >= n_units()) seen_exp = 1'b1;
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("done_en", 32'(o_en), 32'd0);
    chk("done_busy", 32'(o_busy), 32'd0);
    chk("done_ready", 32'(o_rdy), 32'd1);
    chk("done_op", 32'(o_op), 32'(op));
`ifdef ALU_ILLEGAL_OP_FLAG_EN
    chk("illegal_op", 32'(o_io), 32'(s >= n_units()));
    chk("illegal_seen", 32'(o_is), 32'(seen_exp));
`endif
    set_valid(1'b0);
  endtask

  task automatic go_idle();
    set_valid(1'b0);
    tick();
    chk("idle_en", 32'(o_en), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_done", 32'(o_done), 32'd0);
    chk("idle_ready", 32'(o_rdy), 32'd1);
  endtask

  initial begin
    RST = 1'b1;
    v4 = 1'b0;
    v3 = 1'b0;
    ALU_FUN = 4'h0;
    tick();
    tick();
    chk("rst_en", 32'(en4), 32'd0);
    chk("rst_op", 32'(op4), 32'd0);
    chk("rst_busy", 32'(b4), 32'd0);
    chk("rst_done", 32'(d4), 32'd0);
    chk("rst_ready", 32'(r4), 32'd1);
    chk("rst_en3", 32'(en3), 32'd0);
    RST = 1'b0;

    which = 0;
    run_op(4'b0000, 1'b0); go_idle();
    run_op(4'b0110, 1'b0); go_idle();
    run_op(4'b1001, 1'b0); go_idle();
    run_op(4'b1110, 1'b0); go_idle();
    // back-to-back Logic then Shift
    run_op(4'b0101, 1'b0);
    run_op(4'b1111, 1'b0); go_idle();
    // stall: valid held through Arith EXEC with changing ALU_FUN
    run_op(4'b0011, 1'b1);
    run_op(4'b0110, 1'b0); go_idle();

    // reset in first EXEC cycle of Arith
    ALU_FUN = 4'b0001;
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    chk("mid_en_before", 32'(en4), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_en", 32'(en4), 32'd0);
    chk("mid_busy", 32'(b4), 32'd0);
    chk("mid_done", 32'(d4), 32'd0);
    chk("mid_ready", 32'(r4), 32'd1);
    tick();
    chk("mid_no_done", 32'(d4), 32'd0);
    seen_exp = 1'b0;

    for (int i = 0; i < 30; i++) begin
      run_op(4'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 0) go_idle();
    end
    go_idle();

    which = 1;
    seen_exp = 1'b0;
    run_op(4'b1100, 1'b0); go_idle();
    run_op(4'b1000, 1'b0); go_idle();
    run_op(4'b0001, 1'b0); go_idle();
    for (int i = 0; i < 20; i++) begin
      run_op(4'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 0) go_idle();
    end
    go_idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    seen_exp = 1'b0;
`ifdef ALU_ILLEGAL_OP_FLAG_EN
    chk("seen_cleared", 32'(is3), 32'd0);
`endif
    chk("rst3_ready", 32'(r3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
